tlb_refill: RTL and testbench

TLB_REFILL -- requirements
Module: tlb_refill

---
 rtl/tlb_pkg.sv | 22 ++
 rtl/tlb_victim.sv | 26 ++
 rtl/tlb_refill.sv | 99 +++++++++
 tb/tb_tlb_refill.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// tlb_pkg: shared TLB refill defaults, PTE bit positions, TLB entry layout and refill FSM states.
package tlb_pkg;
  localparam int LOG_WAYS_DEF  = 4;
  localparam int VPN_WIDTH_DEF = 23;
  localparam int PFN_WIDTH_DEF = 23;
  localparam int ASID_WIDTH    = 8;
  localparam int ENTRY_WIDTH   = VPN_WIDTH_DEF + PFN_WIDTH_DEF + ASID_WIDTH + 3;
  localparam int PTE_PFN_LSB   = 9;
  localparam int PTE_D         = 2;
  localparam int PTE_V         = 1;
  localparam int PTE_G         = 0;
  // TLB entry field order, MSB first
  typedef struct packed {
    logic                     d;
    logic                     v;
    logic                     g;
    logic [ASID_WIDTH-1:0]    asid;
    logic [VPN_WIDTH_DEF-1:0] vpn;
    logic [PFN_WIDTH_DEF-1:0] pfn;
  } tlb_entry_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE, S_FLT} refill_state_e;
endpackage

// File: rtl/tlb_victim.sv
// tlb_victim: round-robin replacement pointer; with TLB_REFILL_WIRED_EN it skips the WIRED low entries.
module tlb_victim import tlb_pkg::*; #(
  parameter int LOG_WAYS = LOG_WAYS_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [LOG_WAYS-1:0] WIRED,
  input  logic                ADVANCE,
  output logic [LOG_WAYS-1:0] INDEX
);
  localparam logic [LOG_WAYS-1:0] TOP = '1;
  logic [LOG_WAYS-1:0] cnt_q, cnt_d;
`ifdef TLB_REFILL_WIRED_EN
  // a counter left below a freshly raised WIRED is pulled up to it
  assign INDEX = (cnt_q < WIRED) ? WIRED : cnt_q;
  assign cnt_d = ADVANCE ? ((INDEX == TOP) ? WIRED : INDEX + 1'b1) : cnt_q;
`else
  logic unused_wired;
  assign unused_wired = ^WIRED;
  assign INDEX = cnt_q;
  assign cnt_d = ADVANCE ? cnt_q + 1'b1 : cnt_q;
`endif
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) cnt_q <= TOP;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/tlb_refill.sv
// tlb_refill: hardware TLB miss handler reading one PTE per miss, writing the TLB or raising a fault.
// Build with TLB_REFILL_WIRED_EN to protect the low WIRED entries from replacement.
module tlb_refill import tlb_pkg::*; #(
  parameter int LOG_WAYS  = LOG_WAYS_DEF,
  parameter int VPN_WIDTH = VPN_WIDTH_DEF,
  parameter int PFN_WIDTH = PFN_WIDTH_DEF
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             MISS_I,
  input  logic                             MISS_D,
  input  logic [VPN_WIDTH-1:0]             VPN_I,
  input  logic [VPN_WIDTH-1:0]             VPN_D,
  input  logic [ASID_WIDTH-1:0]            C_ASID,
  input  logic [31:0]                      PTBASE,
  input  logic [LOG_WAYS-1:0]              WIRED,
  output logic                             MEM_REQ,
  output logic [31:0]                      MEM_ADDR,
  input  logic                             MEM_ACK,
  input  logic [31:0]                      MEM_RDATA,
  output logic [LOG_WAYS-1:0]              INDEX,
  output logic [VPN_WIDTH+PFN_WIDTH+10:0]  WR_ENTRY,
  output logic                             WE_ENTRY,
  output logic                             BUSY,
  output logic                             FAULT,
  output logic [VPN_WIDTH-1:0]             FAULT_VPN,
  output logic                             FAULT_D
);
  refill_state_e           state_q, state_d;
  logic                    side_q, side_d;
  logic [VPN_WIDTH-1:0]    vpn_q, vpn_d, vpn_pick;
  logic [ASID_WIDTH-1:0]   asid_q, asid_d;
  logic [31:0]             addr_q, addr_d;
  logic [PFN_WIDTH-1:0]    pfn_q, pfn_d;
  logic [2:0]              flags_q, flags_d;
  logic [LOG_WAYS-1:0]     victim;
  logic                    unused_pte;
  tlb_victim #(.LOG_WAYS(LOG_WAYS)) u_victim (
    .CLK    (CLK),
    .RESET  (RESET),
    .WIRED  (WIRED),
    .ADVANCE(state_q == S_WRITE),
    .INDEX  (victim)
  );
  assign vpn_pick   = MISS_D ? VPN_D : VPN_I;
  assign unused_pte = ^MEM_RDATA[PTE_PFN_LSB-1:3];
  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    vpn_d   = vpn_q;
    asid_d  = asid_q;
    addr_d  = addr_q;
    pfn_d   = pfn_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: if (MISS_D || MISS_I) begin
        side_d  = MISS_D;
        vpn_d   = vpn_pick;
        asid_d  = C_ASID;
        // address is frozen here so PTBASE may move while the read is outstanding
        addr_d  = PTBASE + (32'(vpn_pick) << 2);
        state_d = S_REQ;
      end
      S_REQ: if (MEM_ACK) begin
        pfn_d   = PFN_WIDTH'(MEM_RDATA[31:PTE_PFN_LSB]);
        flags_d = MEM_RDATA[2:0];
        state_d = MEM_RDATA[PTE_V] ? S_WRITE : S_FLT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q <= S_IDLE;
      side_q  <= 1'b0;
      vpn_q   <= '0;
      asid_q  <= '0;
      addr_q  <= '0;
      pfn_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      vpn_q   <= vpn_d;
      asid_q  <= asid_d;
      addr_q  <= addr_d;
      pfn_q   <= pfn_d;
      flags_q <= flags_d;
    end
  assign BUSY      = state_q != S_IDLE;
  assign MEM_REQ   = state_q == S_REQ;
  assign MEM_ADDR  = MEM_REQ ? addr_q : '0;
  assign WE_ENTRY  = state_q == S_WRITE;
  assign INDEX     = WE_ENTRY ? victim : '0;
  assign WR_ENTRY  = WE_ENTRY ? {flags_q[PTE_D], flags_q[PTE_V], flags_q[PTE_G], asid_q, vpn_q, pfn_q} : '0;
  assign FAULT     = state_q == S_FLT;
  assign FAULT_VPN = FAULT ? vpn_q : '0;
  assign FAULT_D   = FAULT & side_q;
endmodule

// File: tb/tb_tlb_refill.sv
// tb_tlb_refill: randomized self-checking bench for tlb_refill against a behavioural refill model.
module tb_tlb_refill;
  logic        CLK = 0, RESET = 1, MISS_I = 0, MISS_D = 0, MEM_ACK = 0;
  logic [22:0] VPN_I = 0, VPN_D = 0;
  logic [7:0]  C_ASID = 0;
  logic [31:0] PTBASE = 0, MEM_RDATA = 0;
  logic [3:0]  WIRED = 0;
  logic        MEM_REQ, WE_ENTRY, BUSY, FAULT, FAULT_D;
  logic [31:0] MEM_ADDR;
  logic [3:0]  INDEX;
  logic [56:0] WR_ENTRY;
  logic [22:0] FAULT_VPN;
  int n_chk = 0, n_fail = 0;
  int m_vic = 15;

  always #5 CLK = ~CLK;

  tlb_refill dut (
    .CLK(CLK), .RESET(RESET), .MISS_I(MISS_I), .MISS_D(MISS_D), .VPN_I(VPN_I), .VPN_D(VPN_D),
    .C_ASID(C_ASID), .PTBASE(PTBASE), .WIRED(WIRED), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .INDEX(INDEX), .WR_ENTRY(WR_ENTRY), .WE_ENTRY(WE_ENTRY),
    .BUSY(BUSY), .FAULT(FAULT), .FAULT_VPN(FAULT_VPN), .FAULT_D(FAULT_D)
  );

  function automatic int low_bound();
`ifdef TLB_REFILL_WIRED_EN
    return int'(WIRED);
`else
    return 0;
`endif
  endfunction

  function automatic logic [3:0] model_pick();
    return 4'((m_vic < low_bound()) ? low_bound() : m_vic);
  endfunction

  function automatic void model_advance(input logic [3:0] used);
    m_vic = (used == 4'd15) ? low_bound() : int'(used) + 1;
  endfunction

  task automatic apply_reset();
    RESET = 1;
    @(posedge CLK); #1;
    RESET = 0;
    m_vic = 15;
  endtask

  task automatic do_refill(input bit side, input logic [22:0] vpn, input logic [7:0] asid,
                           input logic [31:0] pte, input int delay, input bit noise,
                           output logic [3:0] idx_seen);
    logic [31:0] exp_addr;
    logic [63:0] got, exp;
    logic [3:0]  exp_idx;
    exp_addr = PTBASE + ({9'b0, vpn} << 2);
    if (side) begin MISS_D = 1; VPN_D = vpn; end
    else begin MISS_I = 1; VPN_I = vpn; end
    C_ASID = asid;
    @(posedge CLK); #1;
    if (side) MISS_D = 0; else MISS_I = 0;
    for (int c = 0; c <= delay; c++) begin
      if (noise) begin
        C_ASID = 8'($urandom);
        PTBASE = $urandom & 32'hFFFF_FFFC;
        MEM_RDATA = $urandom;
        MISS_I = (c < delay) ? 1'($urandom) : 1'b0;
        MISS_D = (c < delay) ? 1'($urandom) : 1'b0;
        VPN_I = 23'($urandom);
        VPN_D = 23'($urandom);
      end
      if (c == delay) begin MEM_ACK = 1; MEM_RDATA = pte; end
      got = {28'b0, BUSY, MEM_REQ, MEM_ADDR, WE_ENTRY, FAULT};
      exp = {28'b0, 1'b1, 1'b1, exp_addr, 1'b0, 1'b0};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL req_phase cycle %0d got=%h expected=%h", c, got, exp);
      end
      @(posedge CLK); #1;
    end
    MEM_ACK = 0;
    MEM_RDATA = $urandom;
    exp_idx = model_pick();
    if (pte[1]) begin
      got = {WE_ENTRY, INDEX, WR_ENTRY, FAULT, MEM_REQ};
      exp = {1'b1, exp_idx, pte[2], pte[1], pte[0], asid, vpn, pte[31:9], 1'b0, 1'b0};
      model_advance(exp_idx);
    end else begin
      got = {30'b0, FAULT, FAULT_D, FAULT_VPN, WE_ENTRY, MEM_REQ, BUSY, 7'b0};
      exp = {30'b0, 1'b1, side, vpn, 1'b0, 1'b0, 1'b1, 7'b0};
    end
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s_phase got=%h expected=%h", pte[1] ? "write" : "fault", got, exp);
    end
    idx_seen = INDEX;
    @(posedge CLK); #1;
    got = {60'b0, BUSY, MEM_REQ, WE_ENTRY, FAULT};
    n_chk++;
    if (got !== 64'b0) begin
      n_fail++;
      $display("FAIL back_to_idle got=%h expected=0", got);
    end
  endtask

  task automatic test_reset();
    logic [127:0] got;
    #1;
    got = {7'b0, BUSY, MEM_REQ, MEM_ADDR, WE_ENTRY, INDEX, WR_ENTRY, FAULT, FAULT_VPN, FAULT_D};
    n_chk++;
    if (got !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h expected=0", got);
    end
    MISS_D = 1; VPN_D = 23'h55;
    @(posedge CLK); #1;
    n_chk++;
    if ({BUSY, MEM_REQ} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_holds_idle got=%b expected=00", {BUSY, MEM_REQ});
    end
    MISS_D = 0;
    RESET = 0;
    m_vic = 15;
  endtask

  task automatic test_spec_example();
    logic [3:0] idx;
    apply_reset();
    WIRED = 0;
    PTBASE = 32'h0010_0000;
    do_refill(1, 23'h000123, 8'h05, 32'h0002_4607, 0, 0, idx);
    n_chk++;
    if (idx !== 4'd15) begin
      n_fail++;
      $display("FAIL spec_example_index got=%0d expected=15", idx);
    end
  endtask

  task automatic test_dual_miss();
    logic [3:0] idx;
    apply_reset();
    WIRED = 0;
    PTBASE = 32'h0020_0000;
    MISS_I = 1; VPN_I = 23'h10;
    do_refill(1, 23'h20, 8'h11, 32'h00AB_C003, 1, 0, idx);
    n_chk++;
    if (idx !== 4'd15) begin
      n_fail++;
      $display("FAIL dual_d_index got=%0d expected=15", idx);
    end
    do_refill(0, 23'h10, 8'h12, 32'h0012_3402, 0, 0, idx);
    n_chk++;
    if (idx !== 4'd0) begin
      n_fail++;
      $display("FAIL dual_i_index got=%0d expected=0", idx);
    end
  endtask

  task automatic test_fault();
    logic [3:0] idx;
    PTBASE = 32'h0004_0000;
    do_refill(1, 23'h000123, 8'h05, 32'h0002_4600, 0, 0, idx);
    do_refill(0, 23'h7F_FFFF, 8'hA5, 32'hFFFF_FFFD, 2, 1, idx);
    do_refill(1, 23'h1, 8'h0, 32'h0000_0105, 0, 0, idx);
  endtask

  task automatic test_wired();
    logic [3:0] idx;
    logic [3:0] exp_seq [4];
`ifdef TLB_REFILL_WIRED_EN
    exp_seq = '{4'd15, 4'd14, 4'd15, 4'd14};
`else
    exp_seq = '{4'd15, 4'd0, 4'd1, 4'd2};
`endif
    apply_reset();
    WIRED = 4'd14;
    for (int i = 0; i < 4; i++) begin
      do_refill(1'(i), 23'(32'h100 + i), 8'(i), 32'h0000_1202 | (i << 12), i, 0, idx);
      n_chk++;
      if (idx !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL wired_seq[%0d] got=%0d expected=%0d", i, idx, exp_seq[i]);
      end
    end
    WIRED = 0;
  endtask

  task automatic test_ack_delay_reset();
    logic [3:0]  idx;
    logic [31:0] exp_addr;
    logic [35:0] got;
    apply_reset();
    PTBASE = 32'h0030_0000;
    do_refill(0, 23'h4_0000, 8'h33, 32'h0BAD_F006, 5, 1, idx);
    apply_reset();
    PTBASE = 32'hFFFF_FFF0;
    exp_addr = 32'hFFFF_FFF0 + (32'h00_0009 << 2);
    MISS_D = 1; VPN_D = 23'h9;
    @(posedge CLK); #1;
    MISS_D = 0;
    for (int c = 0; c < 2; c++) begin
      n_chk++;
      if ({MEM_REQ, MEM_ADDR} !== {1'b1, exp_addr}) begin
        n_fail++;
        $display("FAIL abort_req_hold cycle %0d got=%h expected=%h", c, {MEM_REQ, MEM_ADDR}, {1'b1, exp_addr});
      end
      @(posedge CLK); #1;
    end
    #2 RESET = 1;
    #1;
    got = {BUSY, MEM_REQ, WE_ENTRY, FAULT, MEM_ADDR};
    n_chk++;
    if (got !== 36'b0) begin
      n_fail++;
      $display("FAIL abort_reset_immediate got=%h expected=0", got);
    end
    MEM_ACK = 1; MEM_RDATA = 32'h0000_0207;
    @(posedge CLK); #1;
    RESET = 0;
    m_vic = 15;
    for (int c = 0; c < 3; c++) begin
      got = {32'b0, BUSY, MEM_REQ, WE_ENTRY, FAULT};
      n_chk++;
      if (got !== 36'b0) begin
        n_fail++;
        $display("FAIL abort_late_ack cycle %0d got=%h expected=0", c, got);
      end
      @(posedge CLK); #1;
    end
    MEM_ACK = 0;
    do_refill(1, 23'h9, 8'h1, 32'h0000_0202, 0, 0, idx);
    n_chk++;
    if (idx !== 4'd15) begin
      n_fail++;
      $display("FAIL abort_victim_kept got=%0d expected=15", idx);
    end
  endtask

  task automatic test_random();
    logic [3:0]  idx;
    logic [31:0] pte;
    for (int i = 0; i < 30; i++) begin
      WIRED = 4'($urandom_range(0, 15));
      PTBASE = $urandom & 32'hFFFF_FFFC;
      pte = $urandom;
      pte[1] = ($urandom_range(0, 3) != 0);
      do_refill(1'($urandom), 23'($urandom), 8'($urandom), pte, $urandom_range(0, 3), 1, idx);
    end
  endtask

  initial begin
    test_reset();
    test_spec_example();
    test_dual_miss();
    test_fault();
    test_wired();
    test_ack_delay_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
